read_counter: RTL and testbench
===============================

# read_counter

Read-counter stage of the CDU, directly downstream of the interrogate generator. On each ISS interrogate pulse it samples the quantized resolver error from the error comparators and converts it into a burst of count pulses, each paced by the 51.2 kpps train. The pulses step a wrapping angle counter and are reported as up/down strobes. Optionally, it queues net increments for the AGC over a request/acknowledge handshake.

## Interface
- CNT_W, 16: angle counter width; wraps modulo 2^CNT_W.
- MED_COUNTS, 4: pulses issued for a medium error sample; range 2..255.
- ACC_W, 8: signed width of the AGC pending accumulator.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- _51KPHI  in  1  51.2 kpps pulse train, a level; used on its rising edge.
- ISSIHI  in  1  interrogate pulse, a level; used on its rising edge.
- ERRSGN  in  1  error sign; 1 means counter lags, so count up.
- ERRLVL  in  2  error level: 0 null, 1 fine, 2 medium, 3 coarse.
- AGCACK  in  1  one-cycle AGC acknowledge.
- RDCNT  out  CNT_W  angle counter value.
- CNTUPH  out  1  one-cycle strobe for each up count.
- CNTDNH  out  1  one-cycle strobe for each down count.
- SLEWH  out  1  high while in the SLEW state.
- AGCPLS  out  1  AGC plus request.
- AGCMNS  out  1  AGC minus request.

## Operation
- Edge detection: each of _51KPHI and ISSIHI passes through a 2-flop synchronizer, then a rising-edge detector.
  - This gives an internal one-cycle event, tick for _51KPHI and intg for ISSIHI.
- State machine has three states: IDLE, BURST and SLEW.
- On intg, in any state, latch dir = ERRSGN and act on ERRLVL:
  - null: go to IDLE with remaining = 0.
  - fine: go to BURST with remaining = 1.
  - medium: go to BURST with remaining = MED_COUNTS.
  - coarse: go to SLEW.
- BURST: each tick issues one count and decrements remaining; when remaining reaches 0, go to IDLE.
- SLEW: each tick issues one count; the state persists until the next intg.
- IDLE: ticks are ignored.
- Count operation:
  - Up: RDCNT += 1 and CNTUPH pulses.
  - Down: RDCNT -= 1 and CNTDNH pulses.
  - RDCNT wraps in both directions, with no saturation.
- Simultaneous intg and tick: intg has priority and loads the new command. The same tick is then counted against the new command (fine issues its single count on that cycle).

## Timing
- Reset values: RDCNT = 0 and state = IDLE; every other output is 0.
- Input to event latency: 3 clk cycles from the input rising edge to the tick/intg event (2 synchronizer flops plus the edge register).
- Count latency: RDCNT, CNTUPH and CNTDNH update on the clk edge following the tick event. Strobes are exactly one cycle wide.
- SLEWH is registered and equals (state == SLEW).
- Reset asserted mid-burst clears everything on the same edge. After release, nothing counts until a new intg.

## Configuration
- READ_COUNTER_AGC_EN defined: the AGC pending accumulator is compiled in.
  - Signed ACC_W bits: +1 per up count, −1 per down count.
  - Saturates at ±(2^(ACC_W−1)−1).
- AGC handshake:
  - AGCPLS is a held level while pending > 0; AGCMNS is a held level while pending < 0.
  - On AGCACK with a request high: pending moves one step toward 0, and both requests drop for exactly one cycle.
  - Count and ack in the same cycle: both contributions are applied.
  - AGCACK with no request is ignored.
- READ_COUNTER_AGC_EN undefined: no accumulator is built, AGCPLS and AGCMNS are tied to 0, and AGCACK is unused.

## Structure
- Package cdu_pkg holds:
  - err_lvl_t enum: ERR_NULL, ERR_FINE, ERR_MED, ERR_COARSE.
  - rc_state_t enum: RC_IDLE, RC_BURST, RC_SLEW.
- One sub-module, rise_detect: a 2-flop synchronizer plus edge register. It is instantiated twice, once for _51KPHI and once for ISSIHI.

## Test plan
- Reset, then a single intg with ERRLVL=1 and ERRSGN=1, then 3 ticks: RDCNT = 1, exactly one CNTUPH, state returns to IDLE.
- intg with ERRLVL=2 and ERRSGN=0 from RDCNT = 2, then 10 ticks: exactly 4 CNTDNH and RDCNT = 0xFFFE, which checks the wrap.
- intg with ERRLVL=3, then 20 ticks, then intg with ERRLVL=0: SLEWH is high for the whole interval, there are 20 counts, and SLEWH clears 1 cycle after the second intg event.
- intg and tick events on the same cycle while in SLEW, with a new ERRLVL=1 and the opposite sign: the new direction applies, one count occurs on that cycle, and the state ends in IDLE.
- With READ_COUNTER_AGC_EN: 5 up counts with AGCACK held low give AGCPLS high. Then 5 acks at a 3-cycle spacing: AGCPLS dips for one cycle after each ack and is low after the fifth. Also check saturation at +127 after 130 counts.
- Assert rst mid-burst with 2 pulses remaining: all outputs go to 0 immediately, and later ticks produce no counts.

Source files
------------

// File: rtl/cdu_pkg.sv
// ============================================================================
// Package : cdu_pkg
// Brief   : Shared types for the CDU read-counter stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cdu_pkg;

  typedef enum logic [1:0] {
    ERR_NULL   = 2'd0,
    ERR_FINE   = 2'd1,
    ERR_MED    = 2'd2,
    ERR_COARSE = 2'd3
  } err_lvl_t;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'd0,
    RC_BURST = 2'd1,
    RC_SLEW  = 2'd2
  } rc_state_t;

  localparam int c_REM_W = 8;

  // Burst length for the two burst-producing error levels.
  function automatic logic [c_REM_W-1:0] burst_len(input err_lvl_t lvl, input int med);
    return (lvl == ERR_MED) ? c_REM_W'(med) : c_REM_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
// Module : rise_detect
// Brief  : 2-flop synchronizer plus registered rising-edge detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/read_counter.sv
// ============================================================================
// Module : read_counter
// Brief  : Converts sampled resolver error into paced count bursts on a
//          wrapping angle counter. READ_COUNTER_AGC_EN adds the AGC queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module read_counter
  import cdu_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MED_COUNTS = 4,
  parameter int ACC_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             _51KPHI,
  input  logic             ISSIHI,
  input  logic             ERRSGN,
  input  logic [1:0]       ERRLVL,
  input  logic             AGCACK,
  output logic [CNT_W-1:0] RDCNT,
  output logic             CNTUPH,
  output logic             CNTDNH,
  output logic             SLEWH,
  output logic             AGCPLS,
  output logic             AGCMNS
);

  logic w_tick;
  logic w_intg;

  rise_detect u_tick_det (
    .clk  (clk),
    .rst  (rst),
    .din  (_51KPHI),
    .rise (w_tick)
  );

  rise_detect u_intg_det (
    .clk  (clk),
    .rst  (rst),
    .din  (ISSIHI),
    .rise (w_intg)
  );

  rc_state_t          r_state;
  logic [c_REM_W-1:0] r_rem;
  logic               r_dir;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_up;
  logic               r_dn;
  logic               r_slew;

  rc_state_t          w_state;
  rc_state_t          w_nxt_state;
  logic [c_REM_W-1:0] w_rem;
  logic [c_REM_W-1:0] w_nxt_rem;
  logic               w_dir;
  logic               w_count;

  // A new command is loaded first so a coincident tick counts against it.
  always_comb begin
    w_state = r_state;
    w_rem   = r_rem;
    w_dir   = r_dir;
    if (w_intg) begin
      w_dir = ERRSGN;
      case (err_lvl_t'(ERRLVL))
        ERR_NULL: begin
          w_state = RC_IDLE;
          w_rem   = '0;
        end
        ERR_FINE, ERR_MED: begin
          w_state = RC_BURST;
          w_rem   = burst_len(err_lvl_t'(ERRLVL), MED_COUNTS);
        end
        default: begin
          w_state = RC_SLEW;
          w_rem   = '0;
        end
      endcase
    end
    w_count     = w_tick && (w_state != RC_IDLE);
    w_nxt_state = w_state;
    w_nxt_rem   = w_rem;
    if (w_count && (w_state == RC_BURST)) begin
      w_nxt_rem = w_rem - 1'b1;
      if (w_rem == c_REM_W'(1)) begin
        w_nxt_state = RC_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RC_IDLE;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
      r_slew  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_rem   <= w_nxt_rem;
      r_dir   <= w_dir;
      r_up    <= w_count && w_dir;
      r_dn    <= w_count && !w_dir;
      r_slew  <= (w_nxt_state == RC_SLEW);
      if (w_count) begin
        r_cnt <= w_dir ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
      end
    end
  end

  assign RDCNT  = r_cnt;
  assign CNTUPH = r_up;
  assign CNTDNH = r_dn;
  assign SLEWH  = r_slew;

`ifdef READ_COUNTER_AGC_EN

  localparam logic signed [ACC_W:0] c_SAT_POS = (ACC_W+1)'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0] c_SAT_NEG = -c_SAT_POS;
  localparam logic signed [ACC_W:0] c_ONE     = (ACC_W+1)'(1);

  logic signed [ACC_W-1:0] r_pend;
  logic                    r_pls;
  logic                    r_mns;
  logic                    w_ack_ok;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W-1:0] w_pend_nxt;

  assign w_ack_ok = AGCACK && (r_pls || r_mns);

  // One extra bit of headroom so ack and count can be summed before clamping.
  always_comb begin
    w_sum = {r_pend[ACC_W-1], r_pend};
    if (w_ack_ok) begin
      w_sum = r_pend[ACC_W-1] ? (w_sum + c_ONE) : (w_sum - c_ONE);
    end
    if (w_count && w_dir) begin
      w_sum = w_sum + c_ONE;
    end else if (w_count) begin
      w_sum = w_sum - c_ONE;
    end
    if (w_sum > c_SAT_POS) begin
      w_pend_nxt = c_SAT_POS[ACC_W-1:0];
    end else if (w_sum < c_SAT_NEG) begin
      w_pend_nxt = c_SAT_NEG[ACC_W-1:0];
    end else begin
      w_pend_nxt = w_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_pls  <= 1'b0;
      r_mns  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_pls  <= !w_pend_nxt[ACC_W-1] && (w_pend_nxt != '0) && !w_ack_ok;
      r_mns  <= w_pend_nxt[ACC_W-1] && !w_ack_ok;
    end
  end

  assign AGCPLS = r_pls;
  assign AGCMNS = r_mns;

`else

  logic w_unused_agc;
  assign w_unused_agc = AGCACK | (ACC_W == 0);
  assign AGCPLS       = 1'b0;
  assign AGCMNS       = 1'b0;

`endif

endmodule

`default_nettype wire

// File: tb/tb_read_counter.sv
// ============================================================================
// Module : tb_read_counter
// Brief  : Randomized and directed bench for read_counter against a
//          cycle-level behavioural model. Honors READ_COUNTER_AGC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_read_counter;

  localparam int MED  = 4;
  localparam int SATV = 127;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        _51KPHI = 1'b0;
  logic        ISSIHI = 1'b0;
  logic        ERRSGN = 1'b0;
  logic [1:0]  ERRLVL = 2'd0;
  logic        AGCACK = 1'b0;
  logic [15:0] RDCNT;
  logic        CNTUPH, CNTDNH, SLEWH, AGCPLS, AGCMNS;

  read_counter #(.CNT_W(16), .MED_COUNTS(MED), .ACC_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    ._51KPHI (_51KPHI),
    .ISSIHI  (ISSIHI),
    .ERRSGN  (ERRSGN),
    .ERRLVL  (ERRLVL),
    .AGCACK  (AGCACK),
    .RDCNT   (RDCNT),
    .CNTUPH  (CNTUPH),
    .CNTDNH  (CNTDNH),
    .SLEWH   (SLEWH),
    .AGCPLS  (AGCPLS),
    .AGCMNS  (AGCMNS)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int seen_up = 0;
  int seen_dn = 0;

  // Reference state: mode 0 idle, 1 burst, 2 slew.
  int m_cnt, m_mode, m_rem, m_pend;
  bit m_dir, m_up, m_dn, m_pls, m_mns;
  bit th_t[4];
  bit th_i[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_mode = 0; m_rem = 0; m_pend = 0;
    m_dir = 0; m_up = 0; m_dn = 0; m_pls = 0; m_mns = 0;
    for (int k = 0; k < 4; k++) begin
      th_t[k] = 0;
      th_i[k] = 0;
    end
  endtask

  task automatic model_edge(input bit t, input bit s, input bit a);
    bit te, ie, ack_ok;
    if (rst) begin
      model_clear();
      return;
    end
    // Inputs take three clocks to become events, consumed on the fourth edge.
    te = th_t[2] & ~th_t[3];
    ie = th_i[2] & ~th_i[3];
    th_t[3] = th_t[2]; th_t[2] = th_t[1]; th_t[1] = th_t[0]; th_t[0] = t;
    th_i[3] = th_i[2]; th_i[2] = th_i[1]; th_i[1] = th_i[0]; th_i[0] = s;
    if (ie) begin
      m_dir = ERRSGN;
      case (ERRLVL)
        2'd0: begin m_mode = 0; m_rem = 0; end
        2'd1: begin m_mode = 1; m_rem = 1; end
        2'd2: begin m_mode = 1; m_rem = MED; end
        default: m_mode = 2;
      endcase
    end
    m_up = 0;
    m_dn = 0;
    if (te && m_mode != 0) begin
      if (m_dir) begin m_cnt = (m_cnt + 1) % 65536; m_up = 1; end
      else begin m_cnt = (m_cnt + 65535) % 65536; m_dn = 1; end
      if (m_mode == 1) begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end
    end
`ifdef READ_COUNTER_AGC_EN
    ack_ok = a && (m_pls || m_mns);
    if (ack_ok) m_pend += (m_pend > 0) ? -1 : 1;
    m_pend += int'(m_up) - int'(m_dn);
    if (m_pend > SATV) m_pend = SATV;
    if (m_pend < -SATV) m_pend = -SATV;
    m_pls = (m_pend > 0) && !ack_ok;
    m_mns = (m_pend < 0) && !ack_ok;
`else
    ack_ok = a;
    if (ack_ok) m_pend = 0;
`endif
  endtask

  task automatic compare_all();
    check("rdcnt",  {16'd0, RDCNT},  m_cnt);
    check("cntuph", {31'd0, CNTUPH}, {31'd0, m_up});
    check("cntdnh", {31'd0, CNTDNH}, {31'd0, m_dn});
    check("slewh",  {31'd0, SLEWH},  {31'd0, (m_mode == 2)});
    check("agcpls", {31'd0, AGCPLS}, {31'd0, m_pls});
    check("agcmns", {31'd0, AGCMNS}, {31'd0, m_mns});
    seen_up += int'(CNTUPH);
    seen_dn += int'(CNTDNH);
  endtask

  task automatic step(input bit t, input bit s, input bit a);
    @(negedge clk);
    _51KPHI = t;
    ISSIHI  = s;
    AGCACK  = a;
    @(posedge clk);
    model_edge(t, s, a);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    idle(4);
  endtask

  task automatic intg(input logic [1:0] lvl, input logic sgn);
    ERRLVL = lvl;
    ERRSGN = sgn;
    step(0, 1, 0);
    idle(4);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_clear();
    compare_all();
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    idle(3);
    check("reset_rdcnt", {16'd0, RDCNT}, 0);
    rst = 1'b0;
    idle(2);

    seen_up = 0;
    intg(2'd1, 1'b1);
    ticks(3);
    check("fine_rdcnt", {16'd0, RDCNT}, 1);
    check("fine_ups", seen_up, 1);
    check("fine_idle", {31'd0, SLEWH}, 0);

    intg(2'd1, 1'b1);
    ticks(1);
    seen_dn = 0;
    intg(2'd2, 1'b0);
    ticks(10);
    check("med_wrap", {16'd0, RDCNT}, 32'hFFFE);
    check("med_dns", seen_dn, MED);

    seen_up = 0;
    intg(2'd3, 1'b1);
    check("slew_on", {31'd0, SLEWH}, 1);
    ticks(20);
    check("slew_held", {31'd0, SLEWH}, 1);
    check("slew_ups", seen_up, 20);
    intg(2'd0, 1'b0);
    check("slew_off", {31'd0, SLEWH}, 0);

    intg(2'd3, 1'b1);
    ticks(2);
    seen_up = 0;
    seen_dn = 0;
    ERRLVL = 2'd1;
    ERRSGN = 1'b0;
    step(1, 1, 0);
    idle(6);
    check("coinc_dn", seen_dn, 1);
    check("coinc_up", seen_up, 0);
    check("coinc_idle", {31'd0, SLEWH}, 0);

`ifdef READ_COUNTER_AGC_EN
    async_reset();
    intg(2'd3, 1'b1);
    ticks(5);
    intg(2'd0, 1'b1);
    check("agc_req", {31'd0, AGCPLS}, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
    end
    check("agc_drained", {31'd0, AGCPLS}, 0);
    intg(2'd3, 1'b1);
    ticks(130);
    intg(2'd0, 1'b1);
    for (int k = 0; k < SATV - 1; k++) begin
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
    end
    check("agc_sat_left1", {31'd0, AGCPLS}, 1);
    step(0, 0, 1);
    idle(2);
    check("agc_sat_empty", {31'd0, AGCPLS}, 0);
`endif

    async_reset();
    intg(2'd2, 1'b1);
    ticks(2);
    async_reset();
    check("rst_rdcnt", {16'd0, RDCNT}, 0);
    seen_up = 0;
    seen_dn = 0;
    ticks(3);
    check("rst_nocount", seen_up + seen_dn, 0);
    check("rst_rdcnt2", {16'd0, RDCNT}, 0);

    for (int k = 0; k < 1500; k++) begin
      ERRLVL = 2'($urandom_range(0, 3));
      ERRSGN = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
